// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// Weight-sequence table read controller: walks the C_NUM_SEQ-entry table
// num_iter times under back-pressure, then drains the read latency and pulses done.
module cnn_layer_accel_weight_seq_ctrl #(
  parameter int C_NUM_SEQ    = 5,
  parameter int C_ITER_WIDTH = 16,
  localparam int C_ADDR_WIDTH = $clog2(C_NUM_SEQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [C_ITER_WIDTH-1:0] num_iter,
  input  logic                    stall,
  output logic [C_ADDR_WIDTH-1:0] rdAddr,
  output logic                    rden,
  output logic                    seq_valid,
  output logic                    seq_last,
  output logic                    busy,
  output logic                    done
);

  localparam logic [C_ADDR_WIDTH-1:0] LAST_ADDR = C_ADDR_WIDTH'(C_NUM_SEQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [C_ADDR_WIDTH-1:0] addr;
  logic [C_ITER_WIDTH-1:0] pass_cnt;
  logic [C_ITER_WIDTH-1:0] iter_lat;
  logic                    last_pass;
  logic                    last_issue;

  // The last pass never increments the pass counter, so num_iter = 2^W-1 cannot overflow.
  assign last_pass  = (pass_cnt == iter_lat - C_ITER_WIDTH'(1));
  assign last_issue = (addr == LAST_ADDR) && last_pass;

  assign rdAddr = addr;
  assign rden   = (state == RUN) && !stall;
  assign busy   = (state == RUN) || (state == DRAIN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      pass_cnt  <= '0;
      iter_lat  <= '0;
      seq_valid <= 1'b0;
      seq_last  <= 1'b0;
    end else begin
      // Table read stage -> table output stage (1-cycle read latency)
      seq_valid <= rden;
      seq_last  <= rden && last_issue;

      case (state)
        IDLE: begin
          if (start) begin
            iter_lat <= num_iter;
            addr     <= '0;
            pass_cnt <= '0;
            state    <= (num_iter == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            if (addr == LAST_ADDR) begin
              addr <= '0;
              if (last_pass) state <= DRAIN;
              else pass_cnt <= pass_cnt + C_ITER_WIDTH'(1);
            end else begin
              addr <= addr + C_ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
// Scoreboard bench for the weight-sequence controller: expected table reads are
// queued when a job is started and retired as rden / seq_valid appear.
module tb_cnn_layer_accel_weight_seq_ctrl;

  localparam int NS = 5;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stall;
  logic [IW-1:0] num_iter;
  logic [2:0]    rdAddr;
  logic          rden;
  logic          seq_valid;
  logic          seq_last;
  logic          busy;
  logic          done;

  cnn_layer_accel_weight_seq_ctrl #(.C_NUM_SEQ(NS), .C_ITER_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_iter(num_iter), .stall(stall),
    .rdAddr(rdAddr), .rden(rden), .seq_valid(seq_valid), .seq_last(seq_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   addr;
    logic last;
  } exp_t;

  exp_t q_exp[$];
  logic q_lat[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_rden, n_vld, n_done, n_busy, last_rden_cyc, done_cyc;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rden) begin
      n_rden++;
      last_rden_cyc = cyc;
      if (q_exp.size() == 0) begin
        check("rden_extra", 1, 0);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check("rdAddr", int'(rdAddr), e.addr);
        q_lat.push_back(e.last);
      end
    end
    if (seq_valid) begin
      n_vld++;
      if (q_lat.size() == 0) check("seq_valid_extra", 1, 0);
      else check("seq_last", int'(seq_last), int'(q_lat.pop_front()));
    end else if (seq_last) begin
      check("seq_last_unqualified", 1, 0);
    end
    if (busy) n_busy++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
      check("busy_in_done", int'(busy), 0);
    end
  end

  task automatic push_job(input int n);
    for (int p = 0; p < n; p++)
      for (int a = 0; a < NS; a++)
        q_exp.push_back('{addr: a, last: (p == n - 1) && (a == NS - 1)});
  endtask

  task automatic clear_counts();
    n_rden = 0; n_vld = 0; n_done = 0; n_busy = 0; done_cyc = -1; last_rden_cyc = -1;
  endtask

  task automatic run_job(input int n, input bit do_stall, input bit do_restart);
    int  st;
    bit  stalled;
    bit  restarted;
    clear_counts();
    push_job(n);
    @(posedge clk); #1;
    start = 1'b1; num_iter = IW'(n); st = cyc;
    @(posedge clk); #1;
    start = 1'b0; num_iter = IW'(9);
    stalled = 1'b0; restarted = 1'b0;
    for (int i = 0; i < 300 && n_done == 0; i++) begin
      if (do_stall && !stalled && busy && rdAddr == 3'd2) begin
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_rden", int'(rden), 0);
          check("stall_addr", int'(rdAddr), 2);
          @(posedge clk); #1;
        end
        stall = 1'b0;
        stalled = 1'b1;
      end
      if (do_restart && !restarted && n_rden == 3) begin
        start = 1'b1; num_iter = IW'(7);
        restarted = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (n_done == 0) check("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("n_done", n_done, 1);
    check("n_seq_valid", n_vld, NS * n);
    check("n_rden", n_rden, NS * n);
    check("q_exp_empty", q_exp.size(), 0);
    check("q_lat_empty", q_lat.size(), 0);
    check("busy_after", int'(busy), 0);
    if (n == 0) begin
      check("done_lat_zero", done_cyc - st, 1);
      check("busy_zero_job", n_busy, 0);
    end else begin
      check("done_after_last_rden", done_cyc - last_rden_cyc, 2);
    end
    if (do_stall) check("stall_seen", int'(stalled), 1);
    q_exp.delete();
    q_lat.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; num_iter = '0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdAddr", int'(rdAddr), 0);
    check("rst_rden", int'(rden), 0);
    check("rst_seq_valid", int'(seq_valid), 0);
    check("rst_seq_last", int'(seq_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    run_job(1, 1'b0, 1'b0);
    run_job(3, 1'b0, 1'b0);
    run_job(2, 1'b1, 1'b0);
    run_job(0, 1'b0, 1'b0);
    run_job(2, 1'b0, 1'b1);
    run_job((1 << IW) - 1, 1'b0, 1'b0);

    // Abort a num_iter=2 job on its third read; a start alongside rst must be ignored.
    clear_counts();
    push_job(2);
    @(posedge clk); #1;
    start = 1'b1; num_iter = IW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && !(rden && n_rden == 2); i++) begin
      @(posedge clk); #1;
    end
    check("abort_reached_third_rden", int'(rden && n_rden == 2), 1);
    rst = 1'b1; start = 1'b1; num_iter = IW'(1);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    q_exp.delete();
    q_lat.delete();
    check("abort_rdAddr", int'(rdAddr), 0);
    check("abort_rden", int'(rden), 0);
    check("abort_seq_valid", int'(seq_valid), 0);
    check("abort_seq_last", int'(seq_last), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_stays_idle", int'(busy), 0);

    run_job(1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "bench timeout");
  end

endmodule
